// File: rtl/uart_reg_bridge_if.sv
// Byte and register-bus signals between uart_reg_bridge and its neighbours.
//   master (bridge side): drives rd, wr, txdata, reg_* strobes/address/data, busy, frame_err
//   slave  (environment): drives rxdata, rxdrdy, full, reg_rdata
interface uart_reg_bridge_if;
  logic [7:0] rxdata;
  logic       rxdrdy;
  logic       rd;
  logic [7:0] txdata;
  logic       full;
  logic       wr;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       frame_err;

  modport master (
    input  rxdata, rxdrdy, full, reg_rdata,
    output rd, txdata, wr, reg_addr, reg_wdata, reg_wr, reg_rd, busy, frame_err
  );

  modport slave (
    output rxdata, rxdrdy, full, reg_rdata,
    input  rd, txdata, wr, reg_addr, reg_wdata, reg_wr, reg_rd, busy, frame_err
  );
endinterface

// File: rtl/uart_reg_bridge.sv
// Command responder behind a uart byte interface: decodes 'W' addr data and
// 'R' addr frames into single-cycle register-bus accesses and returns one
// response byte per frame (ACK_BYTE, read data, or ERR_BYTE).
// Ports:
//   clk  - system clock (shared with uart)
//   rst  - synchronous active-high reset
//   bus  - uart_reg_bridge_if.master: rx pop side (rxdata/rxdrdy/rd),
//          tx push side (txdata/full/wr), register bus (reg_*), busy, frame_err
module uart_reg_bridge #(
  parameter int unsigned TIMEOUT  = 1000000,
  parameter int unsigned RD_LAT   = 1,
  parameter logic [7:0]  ERR_BYTE = 8'h3F,
  parameter logic [7:0]  ACK_BYTE = 8'h4B
) (
  input  logic                clk,
  input  logic                rst,
  uart_reg_bridge_if.master   bus
);

  localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [3:0]      LAT_END  = 4'(RD_LAT);
  localparam logic [7:0]      OP_W     = 8'h57;
  localparam logic [7:0]      OP_R     = 8'h52;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_BUS_WR, S_BUS_RD, S_RD_WAIT, S_SEND
  } state_t;

  state_t           state_q, state_d;
  logic             op_wr_q, op_wr_d;
  logic             holdoff_q, holdoff_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]       lat_q, lat_d;
  logic [7:0]       txdata_q, txdata_d;
  logic [7:0]       reg_addr_q, reg_addr_d;
  logic [7:0]       reg_wdata_q, reg_wdata_d;
  logic             reg_wr_q, reg_wr_d;
  logic             reg_rd_q, reg_rd_d;
  logic             frame_err_q, frame_err_d;

  logic rx_expect;
  logic in_frame;
  logic pop;
  logic push;
  logic timeout_hit;

  // Pop/push strobes are same-cycle handshakes with the uart buffers.
  assign rx_expect = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign in_frame  = (state_q == S_ADDR) || (state_q == S_DATA);
  assign pop       = !rst && rx_expect && bus.rxdrdy && !holdoff_q;
  assign push      = !rst && (state_q == S_SEND) && !bus.full;
  // to_cnt_q holds cycles elapsed since the last pop; frame_err lands on cycle TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && in_frame && !pop && (to_cnt_q >= TO_LIMIT);

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    op_wr_d     = op_wr_q;
    holdoff_d   = pop;
    to_cnt_d    = to_cnt_q;
    lat_d       = lat_q;
    txdata_d    = txdata_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    frame_err_d = 1'b0;

    // Saturating byte-gap counter, reloaded on every pop.
    if (pop) begin
      to_cnt_d = CNT_W'(1);
    end else if (in_frame && (to_cnt_q != CNT_MAX)) begin
      to_cnt_d = to_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          if (bus.rxdata == OP_W) begin
            op_wr_d = 1'b1;
            state_d = S_ADDR;
          end else if (bus.rxdata == OP_R) begin
            op_wr_d = 1'b0;
            state_d = S_ADDR;
          end else begin
            txdata_d    = ERR_BYTE;
            frame_err_d = 1'b1;
            state_d     = S_SEND;
          end
        end
      end
      S_ADDR: begin
        if (pop) begin
          reg_addr_d = bus.rxdata;
          state_d    = op_wr_q ? S_DATA : S_BUS_RD;
        end else if (timeout_hit) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_DATA: begin
        if (pop) begin
          reg_wdata_d = bus.rxdata;
          state_d     = S_BUS_WR;
        end else if (timeout_hit) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_BUS_WR: begin
        txdata_d = ACK_BYTE;
        state_d  = S_SEND;
      end
      S_BUS_RD: begin
        lat_d   = 4'd1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (lat_q >= LAT_END) begin
          txdata_d = bus.reg_rdata;
          state_d  = S_SEND;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      S_SEND: begin
        if (push) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    reg_wr_d = (state_d == S_BUS_WR);
    reg_rd_d = (state_d == S_BUS_RD);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_wr_q     <= 1'b0;
      holdoff_q   <= 1'b0;
      to_cnt_q    <= '0;
      lat_q       <= 4'd0;
      txdata_q    <= 8'h00;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_wr_q     <= op_wr_d;
      holdoff_q   <= holdoff_d;
      to_cnt_q    <= to_cnt_d;
      lat_q       <= lat_d;
      txdata_q    <= txdata_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.rd        = pop;
  assign bus.wr        = push;
  assign bus.txdata    = txdata_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_rd    = reg_rd_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Bench for uart_reg_bridge: models the uart rx/tx buffers and a register
// file with one-cycle read latency, runs directed frames and a randomized
// frame stream checked against a frame-level reference model.
module tb_uart_reg_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_reg_bridge_if bus();

  uart_reg_bridge #(
    .TIMEOUT (100),
    .RD_LAT  (1),
    .ERR_BYTE(8'h3F),
    .ACK_BYTE(8'h4B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Environment: rx buffer, tx sink, register file, event logs.
  logic [7:0] rx_q[$];
  logic [7:0] bus_mem[256];
  int cyc = 0;
  bit full_force = 1'b0;
  bit full_rand  = 1'b0;
  bit rd_last = 1'b0, reg_rd_last = 1'b0, prev_rd = 1'b0;
  int rd_adj = 0;
  int pop_cyc[$], wr_cyc[$], wr_val[$];
  int regwr_cyc[$], regwr_addr[$], regwr_data[$];
  int regrd_cyc[$], regrd_addr[$], ferr_cyc[$];

  initial begin
    bus.rxdrdy    = 1'b0;
    bus.rxdata    = 8'h00;
    bus.full      = 1'b0;
    bus.reg_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rd_last && rx_q.size() > 0) rx_q.delete(0);
      bus.rxdrdy    = (rx_q.size() != 0);
      bus.rxdata    = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
      bus.full      = full_force || (full_rand && ($urandom_range(0, 2) == 0));
      bus.reg_rdata = reg_rd_last ? bus_mem[bus.reg_addr] : 8'($urandom);
      #3;
      rd_last     = bus.rd;
      reg_rd_last = bus.reg_rd;
      if (bus.rd) begin
        pop_cyc.push_back(cyc);
        if (prev_rd) rd_adj++;
      end
      prev_rd = bus.rd;
      if (bus.wr) begin
        wr_cyc.push_back(cyc);
        wr_val.push_back(int'(bus.txdata));
      end
      if (bus.reg_wr) begin
        regwr_cyc.push_back(cyc);
        regwr_addr.push_back(int'(bus.reg_addr));
        regwr_data.push_back(int'(bus.reg_wdata));
        bus_mem[bus.reg_addr] = bus.reg_wdata;
      end
      if (bus.reg_rd) begin
        regrd_cyc.push_back(cyc);
        regrd_addr.push_back(int'(bus.reg_addr));
      end
      if (bus.frame_err) ferr_cyc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    pop_cyc.delete(); wr_cyc.delete(); wr_val.delete();
    regwr_cyc.delete(); regwr_addr.delete(); regwr_data.delete();
    regrd_cyc.delete(); regrd_addr.delete(); ferr_cyc.delete();
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    rx_q.push_back(a); rx_q.push_back(b); rx_q.push_back(c);
  endtask

  // Bounded wait until the rx buffer is drained and the bridge stays idle.
  task automatic wait_done(input int max_cyc, input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < max_cyc) begin
      step(1);
      n++;
      if (rx_q.size() == 0 && !bus.busy) quiet++;
      else quiet = 0;
    end
    check({tag, "_done"}, 32'(quiet >= 3), 32'd1);
  endtask

  logic [7:0] ref_mem[256];
  int exp_tx[$], exp_wa[$], exp_wd[$];
  int n_bad;

  initial begin
    for (int i = 0; i < 256; i++) bus_mem[i] = 8'($urandom);
    rst = 1'b1;
    step(3);
    check("rst_ctrl", {26'd0, bus.rd, bus.wr, bus.reg_wr, bus.reg_rd, bus.frame_err, bus.busy}, 32'd0);
    check("rst_data", {8'd0, bus.txdata, bus.reg_addr, bus.reg_wdata}, 32'd0);
    rst = 1'b0;
    step(2);

    // Write frame
    clear_logs();
    send3(8'h57, 8'h10, 8'hA5);
    wait_done(60, "wr");
    check("wr_nregwr", regwr_cyc.size(), 1);
    check("wr_addr", qi(regwr_addr, 0), 32'h10);
    check("wr_data", qi(regwr_data, 0), 32'hA5);
    check("wr_regwr_lat", qi(regwr_cyc, 0), qi(pop_cyc, 2) + 1);
    check("wr_nwr", wr_cyc.size(), 1);
    check("wr_resp", qi(wr_val, 0), 32'h4B);
    check("wr_resp_lat", qi(wr_cyc, 0), qi(pop_cyc, 2) + 2);
    check("wr_busy", bus.busy, 0);

    // Read frame
    clear_logs();
    bus_mem[8'h22] = 8'h3C;
    rx_q.push_back(8'h52); rx_q.push_back(8'h22);
    wait_done(60, "rd");
    check("rd_nregrd", regrd_cyc.size(), 1);
    check("rd_addr", qi(regrd_addr, 0), 32'h22);
    check("rd_regrd_lat", qi(regrd_cyc, 0), qi(pop_cyc, 1) + 1);
    check("rd_resp", qi(wr_val, 0), 32'h3C);
    check("rd_resp_lat", qi(wr_cyc, 0), qi(pop_cyc, 1) + 3);
    check("rd_nregwr", regwr_cyc.size(), 0);

    // Bad opcode, then a normal read
    clear_logs();
    bus_mem[8'h01] = 8'h99;
    rx_q.push_back(8'h41);
    wait_done(60, "bad");
    check("bad_nferr", ferr_cyc.size(), 1);
    check("bad_ferr_lat", qi(ferr_cyc, 0), qi(pop_cyc, 0) + 1);
    check("bad_resp", qi(wr_val, 0), 32'h3F);
    check("bad_noacc", regwr_cyc.size() + regrd_cyc.size(), 0);
    clear_logs();
    rx_q.push_back(8'h52); rx_q.push_back(8'h01);
    wait_done(60, "bad_next");
    check("bad_next_resp", qi(wr_val, 0), 32'h99);
    check("bad_next_nferr", ferr_cyc.size(), 0);

    // Timeout after the opcode byte
    clear_logs();
    rx_q.push_back(8'h57);
    wait_done(200, "to");
    check("to_nferr", ferr_cyc.size(), 1);
    check("to_ferr_lat", qi(ferr_cyc, 0), qi(pop_cyc, 0) + 100);
    check("to_nwr", wr_cyc.size(), 0);
    clear_logs();
    send3(8'h57, 8'h01, 8'h02);
    wait_done(60, "to_next");
    check("to_next_addr", qi(regwr_addr, 0), 32'h01);
    check("to_next_data", qi(regwr_data, 0), 32'h02);
    check("to_next_resp", qi(wr_val, 0), 32'h4B);

    // Backpressure with a buffered second frame
    clear_logs();
    bus_mem[8'h05] = 8'h5A;
    full_force = 1'b1;
    send3(8'h57, 8'h30, 8'h77);
    rx_q.push_back(8'h52); rx_q.push_back(8'h05);
    step(40);
    check("bp_nwr_held", wr_cyc.size(), 0);
    check("bp_npop_held", pop_cyc.size(), 3);
    check("bp_busy_held", bus.busy, 1);
    full_force = 1'b0;
    wait_done(80, "bp");
    check("bp_nwr", wr_cyc.size(), 2);
    check("bp_resp0", qi(wr_val, 0), 32'h4B);
    check("bp_resp1", qi(wr_val, 1), 32'h5A);
    check("bp_order", 32'(qi(pop_cyc, 3) > qi(wr_cyc, 0)), 32'd1);

    // Reset mid-frame
    clear_logs();
    rx_q.push_back(8'h57); rx_q.push_back(8'h10);
    for (int n = 0; n < 50 && pop_cyc.size() < 2; n++) step(1);
    check("rstm_npop", pop_cyc.size(), 2);
    step(1);
    rst = 1'b1;
    step(1);
    check("rstm_ctrl", {26'd0, bus.rd, bus.wr, bus.reg_wr, bus.reg_rd, bus.frame_err, bus.busy}, 32'd0);
    check("rstm_data", {8'd0, bus.txdata, bus.reg_addr, bus.reg_wdata}, 32'd0);
    rst = 1'b0;
    step(1);
    rx_q.push_back(8'h52); rx_q.push_back(8'h10);
    wait_done(60, "rstm");
    check("rstm_nregwr", regwr_cyc.size(), 0);
    check("rstm_nwr", wr_cyc.size(), 1);
    check("rstm_resp", qi(wr_val, 0), 32'hA5);

    // Randomized frame stream against a frame-level model
    clear_logs();
    ref_mem = bus_mem;
    n_bad = 0;
    full_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int kind;
      logic [7:0] a, d, op;
      kind = int'($urandom_range(0, 2));
      a = 8'($urandom);
      d = 8'($urandom);
      if (kind == 0) begin
        send3(8'h57, a, d);
        ref_mem[a] = d;
        exp_tx.push_back(32'h4B);
        exp_wa.push_back(int'(a));
        exp_wd.push_back(int'(d));
      end else if (kind == 1) begin
        rx_q.push_back(8'h52); rx_q.push_back(a);
        exp_tx.push_back(int'(ref_mem[a]));
      end else begin
        op = 8'($urandom);
        while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
        rx_q.push_back(op);
        exp_tx.push_back(32'h3F);
        n_bad++;
      end
      step(int'($urandom_range(0, 8)));
    end
    wait_done(4000, "rand");
    full_rand = 1'b0;
    check("rand_ntx", wr_val.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++) check($sformatf("rand_tx%0d", i), qi(wr_val, i), exp_tx[i]);
    check("rand_nregwr", regwr_addr.size(), exp_wa.size());
    for (int i = 0; i < exp_wa.size(); i++) begin
      check($sformatf("rand_wa%0d", i), qi(regwr_addr, i), exp_wa[i]);
      check($sformatf("rand_wd%0d", i), qi(regwr_data, i), exp_wd[i]);
    end
    check("rand_nferr", ferr_cyc.size(), n_bad);
    check("rd_adjacent", rd_adj, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
